// File: rtl/status_reg.sv
// Processor status register (N V 1 B D I Z C) next to the ALU: flag latching,
// PLP/RTI loads, BIT, SEx/CLx, branch evaluation and IRQ/NMI synchronisation.
module status_reg #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_FLAGS = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] flag_we,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       bit_load,
  input  logic [7:0] operand,
  input  logic       flag_op_en,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic [7:0] p_din,
  input  logic       push_brk,
  input  logic [1:0] br_sel,
  input  logic       br_val,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic [7:0] p_dout,
  output logic       c_flag,
  output logic       bcd,
  output logic       br_taken,
  output logic       irq_req,
  output logic       nmi_pending
);

  logic n_reg, v_reg, d_reg, i_reg, z_reg, c_reg;
  logic n_next, v_next, d_next, i_next, z_next, c_next;

  logic [SYNC_STAGES-1:0] irq_sync_reg, irq_sync_next;
  logic [SYNC_STAGES-1:0] nmi_sync_reg, nmi_sync_next;
  logic                   nmi_prev_reg;
  logic                   nmi_pending_reg, nmi_pending_next;
  logic                   nmi_edge;

  // Stage 0 samples the pin; every later stage copies its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign irq_sync_next[gi] = irq_n;
        assign nmi_sync_next[gi] = nmi_n;
      end else begin : g_rest
        assign irq_sync_next[gi] = irq_sync_reg[gi-1];
        assign nmi_sync_next[gi] = nmi_sync_reg[gi-1];
      end
    end
  endgenerate

  assign nmi_edge         = nmi_prev_reg & ~nmi_sync_reg[SYNC_STAGES-1];
  assign nmi_pending_next = nmi_edge | (nmi_pending_reg & ~nmi_ack);

  // Later assignments win: flag_we, then BIT, then the explicit flag op.
  always_comb begin
    n_next = n_reg;
    v_next = v_reg;
    d_next = d_reg;
    i_next = i_reg;
    z_next = z_reg;
    c_next = c_reg;
    if (p_load) begin
      n_next = p_din[7];
      v_next = p_din[6];
      d_next = p_din[3];
      i_next = p_din[2];
      z_next = p_din[1];
      c_next = p_din[0];
    end else begin
      if (flag_we[3]) n_next = alu_n;
      if (flag_we[2]) v_next = alu_v;
      if (flag_we[1]) z_next = alu_z;
      if (flag_we[0]) c_next = alu_c;
      if (bit_load) begin
        n_next = operand[7];
        v_next = operand[6];
      end
      if (flag_op_en) begin
        case (flag_op)
          3'd0:    c_next = 1'b0;
          3'd1:    c_next = 1'b1;
          3'd2:    i_next = 1'b0;
          3'd3:    i_next = 1'b1;
          3'd4:    v_next = 1'b0;
          3'd5:    d_next = 1'b0;
          3'd6:    d_next = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg           <= RESET_FLAGS[7];
      v_reg           <= RESET_FLAGS[6];
      d_reg           <= RESET_FLAGS[3];
      i_reg           <= RESET_FLAGS[2];
      z_reg           <= RESET_FLAGS[1];
      c_reg           <= RESET_FLAGS[0];
      irq_sync_reg    <= '1;
      nmi_sync_reg    <= '1;
      nmi_prev_reg    <= 1'b1;
      nmi_pending_reg <= 1'b0;
    end else begin
      n_reg           <= n_next;
      v_reg           <= v_next;
      d_reg           <= d_next;
      i_reg           <= i_next;
      z_reg           <= z_next;
      c_reg           <= c_next;
      irq_sync_reg    <= irq_sync_next;
      nmi_sync_reg    <= nmi_sync_next;
      nmi_prev_reg    <= nmi_sync_reg[SYNC_STAGES-1];
      nmi_pending_reg <= nmi_pending_next;
    end
  end

  always_comb begin
    case (br_sel)
      2'd0:    br_taken = (n_reg == br_val);
      2'd1:    br_taken = (v_reg == br_val);
      2'd2:    br_taken = (c_reg == br_val);
      default: br_taken = (z_reg == br_val);
    endcase
  end

  assign p_dout      = {n_reg, v_reg, 1'b1, push_brk, d_reg, i_reg, z_reg, c_reg};
  assign c_flag      = c_reg;
  assign bcd         = d_reg;
  assign irq_req     = ~irq_sync_reg[SYNC_STAGES-1] & ~i_reg;
  assign nmi_pending = nmi_pending_reg;

  // Operand bits below 6 and the unstored P bits 5,4 have no destination.
  logic unused_bits;
  assign unused_bits = ^{operand[5:0], p_din[5:4]};

endmodule

// File: tb/tb_status_reg.sv
// Randomised self-checking bench for status_reg against a flag-table model
// with input-history queues for the interrupt synchronisers.
module tb_status_reg;

  localparam int         S   = 2;
  localparam logic [7:0] RST = 8'h04;

  logic       clk = 1'b0;
  logic       reset, alu_n, alu_v, alu_z, alu_c, bit_load, flag_op_en, p_load;
  logic       push_brk, br_val, irq_n, nmi_n, nmi_ack;
  logic [3:0] flag_we;
  logic [7:0] operand, p_din;
  logic [2:0] flag_op;
  logic [1:0] br_sel;
  logic [7:0] p_dout;
  logic       c_flag, bcd, br_taken, irq_req, nmi_pending;

  status_reg #(.SYNC_STAGES(S), .RESET_FLAGS(RST)) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .alu_n(alu_n), .alu_v(alu_v),
    .alu_z(alu_z), .alu_c(alu_c), .bit_load(bit_load), .operand(operand),
    .flag_op_en(flag_op_en), .flag_op(flag_op), .p_load(p_load), .p_din(p_din),
    .push_brk(push_brk), .br_sel(br_sel), .br_val(br_val), .irq_n(irq_n),
    .nmi_n(nmi_n), .nmi_ack(nmi_ack), .p_dout(p_dout), .c_flag(c_flag), .bcd(bcd),
    .br_taken(br_taken), .irq_req(irq_req), .nmi_pending(nmi_pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Model: P as a byte (bits 5,4 kept 0); h[k] = pin value sampled k edges ago.
  bit [7:0] m_p;
  bit       m_pend;
  bit       irq_h[1:S+1];
  bit       nmi_h[1:S+1];
  // Flag-op table: target bit position and value written, op 7 has no entry.
  int       op_pos[0:6] = '{0, 0, 2, 2, 6, 3, 3};
  bit       op_val[0:6] = '{0, 1, 0, 1, 0, 0, 1};
  int       br_pos[0:3] = '{7, 6, 0, 1};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
    end
  endtask

  task automatic check_model();
    bit [7:0] exp_dout;
    exp_dout = {m_p[7:6], 1'b1, push_brk, m_p[3:0]};
    check("p_dout", p_dout, exp_dout);
    check("c_flag", {7'd0, c_flag}, {7'd0, m_p[0]});
    check("bcd", {7'd0, bcd}, {7'd0, m_p[3]});
    check("br_taken", {7'd0, br_taken}, {7'd0, m_p[br_pos[br_sel]] == br_val});
    check("irq_req", {7'd0, irq_req}, {7'd0, !irq_h[S] && !m_p[2]});
    check("nmi_pending", {7'd0, nmi_pending}, {7'd0, m_pend});
  endtask

  task automatic step();
    bit [7:0] np;
    @(posedge clk);
    if (reset) begin
      m_p    = RST & 8'hCF;
      m_pend = 1'b0;
      for (int k = 1; k <= S + 1; k++) begin
        irq_h[k] = 1'b1;
        nmi_h[k] = 1'b1;
      end
    end else begin
      m_pend = (nmi_h[S+1] && !nmi_h[S]) || (m_pend && !nmi_ack);
      np = m_p;
      if (p_load) begin
        np = p_din & 8'hCF;
      end else begin
        if (flag_we[3]) np[7] = alu_n;
        if (flag_we[2]) np[6] = alu_v;
        if (flag_we[1]) np[1] = alu_z;
        if (flag_we[0]) np[0] = alu_c;
        if (bit_load) np[7:6] = operand[7:6];
        if (flag_op_en && flag_op != 3'd7) np[op_pos[flag_op]] = op_val[flag_op];
      end
      m_p = np;
      for (int k = S + 1; k > 1; k--) begin
        irq_h[k] = irq_h[k-1];
        nmi_h[k] = nmi_h[k-1];
      end
      irq_h[1] = irq_n;
      nmi_h[1] = nmi_n;
    end
    cycle++;
    #1;
    $display("cyc=%0d rst=%0b pl=%0b op=%0b/%0d bl=%0b we=%h irq_n=%0b nmi_n=%0b ack=%0b -> p=%h irq=%0b nmi=%0b",
             cycle, reset, p_load, flag_op_en, flag_op, bit_load, flag_we, irq_n, nmi_n,
             nmi_ack, p_dout, irq_req, nmi_pending);
    check_model();
  endtask

  task automatic idle();
    reset = 0; flag_we = 0; alu_n = 0; alu_v = 0; alu_z = 0; alu_c = 0;
    bit_load = 0; operand = 0; flag_op_en = 0; flag_op = 3'd7; p_load = 0;
    p_din = 0; push_brk = 0; br_sel = 0; br_val = 0; nmi_ack = 0;
  endtask

  initial begin
    idle();
    irq_n = 1; nmi_n = 1; reset = 1;
    step();
    check("rst_p_dout", p_dout, 8'h24);
    check("rst_c_flag", {7'd0, c_flag}, 8'd0);
    check("rst_irq_req", {7'd0, irq_req}, 8'd0);
    push_brk = 1; #1;
    check("push_brk_dout", p_dout, 8'h34);

    idle();
    flag_we = 4'b1111; alu_n = 1; alu_v = 0; alu_z = 1; alu_c = 1;
    step();
    check("alu_we_dout", p_dout, 8'hA7);
    check("alu_we_c", {7'd0, c_flag}, 8'd1);

    idle();
    p_load = 1; p_din = 8'hCB; flag_op_en = 1; flag_op = 3'd1;
    flag_we = 4'b1111;
    step();
    check("pload_dout", p_dout, 8'hEB);
    check("pload_bcd", {7'd0, bcd}, 8'd1);

    idle();
    bit_load = 1; operand = 8'h40; flag_we = 4'b1110; alu_n = 1; alu_z = 1;
    br_sel = 2'd1; br_val = 1;
    step();
    check("bit_nvz", {5'd0, p_dout[7], p_dout[6], p_dout[1]}, 8'b011);
    check("bit_br_taken", {7'd0, br_taken}, 8'd1);

    idle();
    irq_n = 0;
    for (int j = 1; j <= S; j++) begin
      step();
      check("irq_latency", {7'd0, irq_req}, {7'd0, j == S});
    end
    flag_op_en = 1; flag_op = 3'd3;
    step();
    check("sei_masks", {7'd0, irq_req}, 8'd0);
    irq_n = 1; flag_op = 3'd2;
    step();
    idle();
    for (int j = 0; j < S; j++) step();

    nmi_n = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      check("nmi_set", {7'd0, nmi_pending}, {7'd0, j >= S + 1});
    end
    nmi_ack = 1;
    step();
    check("nmi_ack", {7'd0, nmi_pending}, 8'd0);
    nmi_ack = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("nmi_no_reset", {7'd0, nmi_pending}, 8'd0);
    end
    nmi_n = 1;
    for (int j = 0; j < S + 1; j++) step();
    nmi_n = 0;
    for (int j = 0; j < S + 1; j++) step();
    check("nmi_new_edge", {7'd0, nmi_pending}, 8'd1);
    nmi_n = 1; nmi_ack = 1;
    step();

    for (int t = 0; t < 500; t++) begin
      reset      = ($urandom_range(0, 63) == 0);
      flag_we    = 4'($urandom);
      {alu_n, alu_v, alu_z, alu_c} = 4'($urandom);
      bit_load   = ($urandom_range(0, 3) == 0);
      operand    = 8'($urandom);
      flag_op_en = ($urandom_range(0, 2) == 0);
      flag_op    = 3'($urandom);
      p_load     = ($urandom_range(0, 7) == 0);
      p_din      = 8'($urandom);
      push_brk   = 1'($urandom);
      br_sel     = 2'($urandom);
      br_val     = 1'($urandom);
      nmi_ack    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
